// File: rtl/vit_act_mul_arbiter_if.sv
// Bundle between the requesters, the shared external multiplier and the result consumer.
// The slave modport is the arbiter's view; master is the environment's view.
interface vit_act_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 8,
  parameter int P_WIDTH = 24
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic        [NUM_REQ-1:0]         req_valid;
  logic        [NUM_REQ-1:0]         req_ready;
  logic        [NUM_REQ*A_WIDTH-1:0] req_a;
  logic        [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                              mul_ce;
  logic signed [A_WIDTH-1:0]         mul_din0;
  logic        [B_WIDTH-1:0]         mul_din1;
  logic signed [P_WIDTH-1:0]         mul_dout;
  logic                              rsp_valid;
  logic                              rsp_ready;
  logic        [ID_W-1:0]            rsp_id;
  logic signed [P_WIDTH-1:0]         rsp_data;
  logic        [31:0]                issue_cnt;

  modport slave (
    input  req_valid, req_a, req_b, mul_dout, rsp_ready,
    output req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data, issue_cnt
  );

  modport master (
    output req_valid, req_a, req_b, mul_dout, rsp_ready,
    input  req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data, issue_cnt
  );
endinterface

// File: rtl/vit_act_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed x unsigned multiplier among NUM_REQ
// requesters; a tag pipeline tracks which requester owns each product in flight.
module vit_act_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3,
  parameter int A_WIDTH     = 16,
  parameter int B_WIDTH     = 8,
  parameter int P_WIDTH     = 24
) (
  input logic                   clk,
  input logic                   reset,
  vit_act_mul_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [31:0]             issue_cnt_q, issue_cnt_d;
  logic [MUL_LATENCY-1:0]  tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]         tag_id_q [MUL_LATENCY];
  logic [ID_W-1:0]         tag_id_d [MUL_LATENCY];

  logic [ID_W-1:0]         scan_idx;
  logic [ID_W-1:0]         grant;
  logic                    any_vld;
  logic                    mul_ce;
  logic                    issue;
  logic                    rsp_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic signed [A_WIDTH-1:0] din0;
  logic [B_WIDTH-1:0]      din1;

  // Scan from rr_ptr upward (with wrap) and take the first valid requester.
  always_comb begin
    grant    = '0;
    any_vld  = 1'b0;
    scan_idx = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_vld && bus.req_valid[scan_idx]) begin
        grant   = scan_idx;
        any_vld = 1'b1;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  assign rsp_valid = tag_vld_q[MUL_LATENCY-1];

  always_comb begin
    mul_ce    = !reset && !(rsp_valid && !bus.rsp_ready);
    issue     = any_vld && mul_ce;
    req_ready = '0;
    din0      = '0;
    din1      = '0;
    if (any_vld) begin
      req_ready[grant] = mul_ce;
      din0             = bus.req_a[int'(grant)*A_WIDTH +: A_WIDTH];
      din1             = bus.req_b[int'(grant)*B_WIDTH +: B_WIDTH];
    end
  end

  always_comb begin
    rr_ptr_d    = issue ? wrap_inc(grant) : rr_ptr_q;
    issue_cnt_d = issue_cnt_q + {31'b0, issue};
  end

  // Tag pipeline: mirrors the multiplier stages, so it moves only on mul_ce.
  always_comb begin
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    if (mul_ce) begin
      tag_vld_d[0] = issue;
      tag_id_d[0]  = grant;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        tag_vld_d[s] = tag_vld_q[s-1];
        tag_id_d[s]  = tag_id_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      issue_cnt_q <= '0;
      tag_vld_q   <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) tag_id_q[s] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      issue_cnt_q <= issue_cnt_d;
      tag_vld_q   <= tag_vld_d;
      for (int s = 0; s < MUL_LATENCY; s++) tag_id_q[s] <= tag_id_d[s];
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mul_ce    = mul_ce;
  assign bus.mul_din0  = din0;
  assign bus.mul_din1  = din1;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = tag_id_q[MUL_LATENCY-1];
  assign bus.rsp_data  = bus.mul_dout;
  assign bus.issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_vit_act_mul_arbiter.sv
// Directed bench for vit_act_mul_arbiter with a clock-enabled 3-stage multiplier model.
module tb_vit_act_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 3;
  localparam int A_W     = 16;
  localparam int B_W     = 8;
  localparam int P_W     = 24;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vit_act_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .A_WIDTH(A_W), .B_WIDTH(B_W), .P_WIDTH(P_W)) bus ();

  vit_act_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .MUL_LATENCY(LAT), .A_WIDTH(A_W), .B_WIDTH(B_W), .P_WIDTH(P_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External multiplier: signed a times unsigned b, LAT stages, advancing on mul_ce.
  logic signed [P_W-1:0] mpipe [LAT];
  logic signed [P_W-1:0] mprod;
  assign mprod = $signed(bus.mul_din0) * $signed({1'b0, bus.mul_din1});
  always @(posedge clk) begin
    if (bus.mul_ce) begin
      mpipe[0] <= mprod;
      for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
    end
  end
  assign bus.mul_dout = mpipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic signed [A_W-1:0] a, input logic [B_W-1:0] b);
    bus.req_a[i*A_W +: A_W] = a;
    bus.req_b[i*B_W +: B_W] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int rr_exp [4] = '{200, 600, 1200, 2000};
  int bp_exp [3] = '{-15, 70, 255000};
  int ex_exp [3] = '{-8355840, 8355585, 0};

  initial begin
    reset         = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (2) @(negedge clk);

    // Reset state, with requests pending
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_mul_ce",    bus.mul_ce,    1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id",    bus.rsp_id,    2'd0);
    chk("rst_issue_cnt", bus.issue_cnt, 32'd0);

    // Single request in the first cycle after release
    @(negedge clk);
    reset         = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    set_lane(0, -300, 200);
    #1;
    chk("single_ready", bus.req_ready, 4'b0001);
    chk("single_ce",    bus.mul_ce,    1'b1);
    chk("single_din0",  bus.mul_din0,  -300);
    chk("single_din1",  bus.mul_din1,  200);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("single_t1_vld",  bus.rsp_valid, 1'b0);
    chk("idle_din0_zero", bus.mul_din0,  0);
    @(negedge clk); #1;
    chk("single_t2_vld", bus.rsp_valid, 1'b0);
    @(negedge clk); #1;
    chk("single_t3_vld",  bus.rsp_valid, 1'b1);
    chk("single_t3_id",   bus.rsp_id,    2'd0);
    chk("single_t3_data", bus.rsp_data,  -60000);
    chk("single_cnt",     bus.issue_cnt, 32'd1);
    @(negedge clk); #1;
    chk("single_t4_vld", bus.rsp_valid, 1'b0);

    // Round robin with all four requesting for 8 cycles
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, (i + 1) * 100, i + 2);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk);
      bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) chk("rr_grant", bus.req_ready, 4'b0001 << (k % 4));
      if (k >= 3) begin
        chk("rr_rsp_vld",  bus.rsp_valid, 1'b1);
        chk("rr_rsp_id",   bus.rsp_id,    (k - 3) % 4);
        chk("rr_rsp_data", bus.rsp_data,  rr_exp[(k - 3) % 4]);
      end
    end
    @(negedge clk); #1;
    chk("rr_drain_vld", bus.rsp_valid, 1'b0);
    chk("rr_cnt",       bus.issue_cnt, 32'd8);

    // Backpressure: stall 5 cycles on the first result
    do_reset();
    set_lane(0, -5, 3);
    set_lane(1, 7, 10);
    set_lane(2, 1000, 255);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 3)      bus.req_valid = 4'b0111;
      else if (k < 8) bus.req_valid = 4'b0001;
      else            bus.req_valid = 4'b0000;
      bus.rsp_ready = (k >= 3 && k < 8) ? 1'b0 : 1'b1;
      #1;
      if (k < 3) chk("bp_grant", bus.req_ready, 4'b0001 << k);
      if (k >= 3 && k < 8) begin
        chk("bp_hold_vld",   bus.rsp_valid, 1'b1);
        chk("bp_hold_id",    bus.rsp_id,    2'd0);
        chk("bp_hold_data",  bus.rsp_data,  -15);
        chk("bp_hold_ready", bus.req_ready, 4'b0000);
        chk("bp_hold_ce",    bus.mul_ce,    1'b0);
        chk("bp_hold_cnt",   bus.issue_cnt, 32'd3);
      end
      if (k >= 8 && k < 11) begin
        chk("bp_rel_vld",  bus.rsp_valid, 1'b1);
        chk("bp_rel_id",   bus.rsp_id,    k - 8);
        chk("bp_rel_data", bus.rsp_data,  bp_exp[k - 8]);
      end
      if (k == 11) begin
        chk("bp_end_vld", bus.rsp_valid, 1'b0);
        chk("bp_end_cnt", bus.issue_cnt, 32'd3);
      end
    end

    // Operand extremes
    do_reset();
    set_lane(0, -32768, 255);
    set_lane(1, 32767, 255);
    set_lane(2, 0, 0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      bus.req_valid = (k < 3) ? 4'b0111 : 4'b0000;
      #1;
      if (k == 0) chk("ext_din0_min", bus.mul_din0, -32768);
      if (k >= 3) begin
        chk("ext_vld",  bus.rsp_valid, 1'b1);
        chk("ext_id",   bus.rsp_id,    k - 3);
        chk("ext_data", bus.rsp_data,  ex_exp[k - 3]);
      end
    end

    // Reset pulse one cycle before the first result
    do_reset();
    set_lane(0, 11, 1);
    set_lane(1, 22, 1);
    set_lane(3, 44, 2);
    bus.req_valid = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = 4'b0000;
    #1;
    chk("mid_rst_vld",   bus.rsp_valid, 1'b0);
    chk("mid_rst_ce",    bus.mul_ce,    1'b0);
    chk("mid_rst_cnt",   bus.issue_cnt, 32'd0);
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = 4'b1010;
    #1;
    chk("mid_grant_low", bus.req_ready, 4'b0010);
    chk("mid_t3_vld",    bus.rsp_valid, 1'b0);
    chk("mid_cnt0",      bus.issue_cnt, 32'd0);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    chk("mid_t4_vld", bus.rsp_valid, 1'b0);
    @(negedge clk); #1;
    chk("mid_t5_vld", bus.rsp_valid, 1'b0);
    @(negedge clk); #1;
    chk("mid_new_vld",  bus.rsp_valid, 1'b1);
    chk("mid_new_id",   bus.rsp_id,    2'd1);
    chk("mid_new_data", bus.rsp_data,  22);

    // Counter wrap
    @(negedge clk);
    force dut.issue_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.issue_cnt_q;
    #1;
    chk("wrap_preset", bus.issue_cnt, 32'hFFFF_FFFF);
    bus.req_valid = 4'b0001;
    #1;
    chk("wrap_ready", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    chk("wrap_cnt", bus.issue_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
